// File: rtl/universal_shift_register_pkg.sv
// Purpose: shared mode encoding for the universal shift register.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no flow control in this block family).
package universal_shift_register_pkg;

    // Operation select carried on the mode port.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage : universal_shift_register_pkg

// File: rtl/universal_shift_register_bit_mux.sv
// Purpose: per-bit 4:1 next-state select (hold / from-left / from-right / load).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module usr_bit_mux
    import universal_shift_register_pkg::*;
(
    input  mode_t i_mode,
    input  logic  i_hold,
    input  logic  i_from_left,
    input  logic  i_from_right,
    input  logic  i_load,
    output logic  o_next
);

    // Pick this bit's next value; an illegal mode falls back to hold.
    always_comb begin
        o_next = i_hold;
        case (i_mode)
            MODE_HOLD: o_next = i_hold;
            MODE_SHR:  o_next = i_from_left;
            MODE_SHL:  o_next = i_from_right;
            MODE_LOAD: o_next = i_load;
            default:   o_next = i_hold;
        endcase
    end

endmodule : usr_bit_mux

// File: rtl/universal_shift_register.sv
// Purpose: WIDTH-bit register with hold, shift right, shift left and parallel load.
// Latency: one clock from mode/d sampling to q; q is purely registered.
// Backpressure: none; an operation is performed on every rising edge.
module universal_shift_register
    import universal_shift_register_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_from_left;
    logic [WIDTH-1:0] w_from_right;
    logic [WIDTH-1:0] w_next;

    // Neighbour wiring: "left" is the next-higher bit (feeds a right shift),
    // "right" is the next-lower bit (feeds a left shift). Edges shift in zero.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign w_from_left[gi] = 1'b0;
            end else begin : g_not_msb
                assign w_from_left[gi] = r_q[gi+1];
            end

            if (gi == 0) begin : g_lsb
                assign w_from_right[gi] = 1'b0;
            end else begin : g_not_lsb
                assign w_from_right[gi] = r_q[gi-1];
            end

            usr_bit_mux u_bit_mux (
                .i_mode      (mode),
                .i_hold      (r_q[gi]),
                .i_from_left (w_from_left[gi]),
                .i_from_right(w_from_right[gi]),
                .i_load      (d[gi]),
                .o_next      (w_next[gi])
            );
        end
    endgenerate

    // State register; reset wins over every mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    localparam int W    = 4;
    localparam int MODV = 1 << W;

    logic         clk;
    logic         reset;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] q;

    int n_checks;
    int n_fail;

    // Behavioural reference: register value as an integer in [0, 2^W).
    int model_val;
    bit model_valid;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .mode (mode),
        .d    (d),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next value from the operation rules, in plain arithmetic.
    function automatic int model_next(int cur, bit rst, int m, int dv);
        if (rst) return 0;
        case (m)
            1:       return cur / 2;
            2:       return (cur * 2) % MODV;
            3:       return dv % MODV;
            default: return cur;
        endcase
    endfunction

    task automatic check(string name, logic [W-1:0] act, int exp);
        logic [W-1:0] e;
        e = exp[W-1:0];
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: q=%b expected=%b at t=%0t", name, act, e, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, settle.
    task automatic step(bit rst, int m, int dv);
        reset = rst;
        mode  = m[1:0];
        d     = dv[W-1:0];
        @(posedge clk);
        model_val = model_next(model_val, rst, m, dv);
        if (rst) model_valid = 1'b1;
        #1;
    endtask

    task automatic step_lit(string name, bit rst, int m, int dv, int exp);
        step(rst, m, dv);
        check(name, q, exp);
    endtask

    // Cycle-by-cycle comparison against the model once reset has been seen.
    always @(negedge clk) begin
        if (model_valid) check("model", q, model_val);
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        model_val   = 0;
        model_valid = 1'b0;
        reset = 1'b1;
        mode  = 2'b00;
        d     = '0;

        // Reset and reset priority over load.
        step_lit("reset",          1, 0, 4'b0000, 4'b0000);
        step_lit("reset_over_ld",  1, 3, 4'b1111, 4'b0000);

        // Load then hold with junk on d.
        step_lit("load_1010",      0, 3, 4'b1010, 4'b1010);
        for (int i = 0; i < 3; i++)
            step_lit("hold_1010",  0, 0, $urandom_range(0, MODV-1), 4'b1010);

        // Shift right.
        step_lit("shr_1010",       0, 1, 4'b1111, 4'b0101);
        step_lit("load_1111",      0, 3, 4'b1111, 4'b1111);
        step_lit("shr_1",          0, 1, 4'b1111, 4'b0111);
        step_lit("shr_2",          0, 1, 4'b0000, 4'b0011);
        step_lit("shr_3",          0, 1, 4'b1010, 4'b0001);
        step_lit("shr_4",          0, 1, 4'b0101, 4'b0000);

        // Shift left.
        step_lit("load_0101",      0, 3, 4'b0101, 4'b0101);
        step_lit("shl_0101",       0, 2, 4'b1111, 4'b1010);
        step_lit("load_1111b",     0, 3, 4'b1111, 4'b1111);
        step_lit("shl_1",          0, 2, 4'b0000, 4'b1110);
        step_lit("shl_2",          0, 2, 4'b1111, 4'b1100);
        step_lit("shl_3",          0, 2, 4'b0011, 4'b1000);
        step_lit("shl_4",          0, 2, 4'b1001, 4'b0000);

        // Mode switching every cycle, d changing in non-load modes.
        step_lit("sw_load_1001",   0, 3, 4'b1001, 4'b1001);
        step_lit("sw_shr",         0, 1, 4'b1111, 4'b0100);
        step_lit("sw_shl",         0, 2, 4'b0011, 4'b1000);
        step_lit("sw_hold",        0, 0, 4'b0111, 4'b1000);
        step_lit("sw_load_0110",   0, 3, 4'b0110, 4'b0110);

        // Reset in the middle of a shift sequence.
        step_lit("mid_load_1111",  0, 3, 4'b1111, 4'b1111);
        step_lit("mid_shr",        0, 1, 4'b0000, 4'b0111);
        step_lit("mid_reset",      1, 1, 4'b1111, 4'b0000);
        step_lit("mid_after_1",    0, 1, 4'b1111, 4'b0000);
        step_lit("mid_after_2",    0, 1, 4'b1111, 4'b0000);

        // Randomised traffic, loads weighted up so shifts have data to move.
        for (int i = 0; i < 2000; i++) begin
            int  m;
            bit  r;
            r = ($urandom_range(0, 31) == 0);
            m = ($urandom_range(0, 3) == 0) ? 3 : $urandom_range(0, 3);
            step(r, m, $urandom_range(0, MODV-1));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_universal_shift_register

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parameterised universal shift register with one clock and a synchronous, active-high reset. A 2-bit mode input selects one of four operations each cycle: hold, shift right, shift left or parallel load. The block is a general-purpose datapath/storage element used wherever a loadable, bidirectionally shiftable register is needed. It has no serial data ports; shifted-in bits are zero.

Parameters:
WIDTH, 4, register width in bits (minimum 2).

Ports:
clk  input  1  rising-edge clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk
mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load
d  input  WIDTH  parallel load data; used only when mode=11
q  output  WIDTH  registered register contents

Behaviour:
- Single WIDTH-bit register drives q directly. No combinational path from inputs to q.
- Reset: when reset=1 at a rising clk edge, q becomes 0 regardless of mode and d. Reset has priority over every mode.
- Until the first reset edge, q is X. Benches must reset before checking outputs.
- With reset=0, at each rising clk edge:
  - mode=00 (hold): q keeps its value.
  - mode=01 (shift right): q[WIDTH-2:0] <= q[WIDTH-1:1]; q[WIDTH-1] <= 0. The LSB is discarded.
  - mode=10 (shift left): q[WIDTH-1:1] <= q[WIDTH-2:0]; q[0] <= 0. The MSB is discarded.
  - mode=11 (load): q <= d.
- Latency: one clock. The new value is visible on q after the edge at which mode and d were sampled.
- Modes are held level-sensitive. A mode held for N cycles performs N operations: shifting N>=WIDTH times yields 0.
- d is ignored in modes 00, 01 and 10.
- Reset asserted mid-sequence clears q on that edge. The operation resumes from 0 on the first edge after reset deasserts.
- No handshake, no enables, no status outputs.
- X/Z on mode with reset=0 is not a legal input. The implementation may treat it as hold (default branch).

Decomposition:
- Shared package universal_shift_register_pkg holds:
  - a 2-bit mode typedef (mode_t);
  - localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
- No sub-module is required. The optional per-bit 4:1 select cell, usr_bit_mux, takes four inputs: hold, from-left neighbour, from-right neighbour and d[i]. It is instantiated WIDTH times with generate. Boundary neighbours are tied to 0.
- The top-level module name is universal_shift_register. The port names clk, reset, mode, d and q are fixed.

Test Plan:
- Reset: reset=1, mode=00, d=0000 for one edge -> q=0000. Then reset=1 with mode=11, d=1111 -> q stays 0000 (reset priority).
- Load then hold: reset=0, mode=11, d=1010 -> q=1010 after one edge. Then mode=00 for 3 edges -> q=1010 throughout.
- Shift right: from q=1010, mode=01 one edge -> q=0101. Four edges from q=1111 -> 0111, 0011, 0001, 0000.
- Shift left: from q=0101, mode=10 one edge -> q=1010. Four edges from q=1111 -> 1110, 1100, 1000, 0000.
- Mode switching each cycle: load 1001 -> shr gives 0100 -> shl gives 1000 -> hold gives 1000 -> load 0110 gives 0110. d changes during non-load modes do not affect q.
- Reset mid-operation: shifting from q=1111 with mode=01, assert reset for one edge -> q=0000. Deassert -> shifting continues from 0000 and q stays 0000.
